window_5x5: RTL and testbench

// - Downstream of the 4-deep row-buffer chain: takes the 5 vertically aligned row taps
//   (live pixel + 4 delayed rows) and shifts them into a 5x5 register window for the conv engine.
// - Tracks the (row, col) position of each accepted pixel and pulses win_valid only when all
//   25 window entries hold real frame pixels from the same 5 rows.

---
 rtl/window_5x5_if.sv | 43 ++++
 rtl/window_5x5.sv | 116 +++++++++++
 tb/tb_window_5x5.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/window_5x5_if.sv
// window_5x5_if: pixel-tap input and window output bundle for window_5x5.
//   master : pixel source / window consumer
//            (drives en, clr, in0..in4; receives window, win_valid, win_row, win_col, frame_done)
//   slave  : window_5x5 itself
// Ports carried:
//   en, clr          pixel strobe and synchronous frame restart
//   in0..in4         row taps, in0 = newest row, in4 = oldest row
//   window           w[r][c] at bits [(r*5+c)*BIT_WIDTH +: BIT_WIDTH]
//   win_valid        1-cycle pulse, window is a full 5x5 frame neighbourhood
//   win_row, win_col frame position of the window's bottom-right pixel
//   frame_done       1-cycle pulse after the last pixel of a frame
interface window_5x5_if #(
  parameter int unsigned LENGTH    = 32,
  parameter int unsigned HEIGHT    = 32,
  parameter int unsigned BIT_WIDTH = 8
);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned COL_W = $clog2(LENGTH);
  localparam int unsigned WIN_W = 25 * BIT_WIDTH;

  logic                 en;
  logic                 clr;
  logic [BIT_WIDTH-1:0] in0;
  logic [BIT_WIDTH-1:0] in1;
  logic [BIT_WIDTH-1:0] in2;
  logic [BIT_WIDTH-1:0] in3;
  logic [BIT_WIDTH-1:0] in4;
  logic [WIN_W-1:0]     window;
  logic                 win_valid;
  logic [ROW_W-1:0]     win_row;
  logic [COL_W-1:0]     win_col;
  logic                 frame_done;

  modport master (
    output en, clr, in0, in1, in2, in3, in4,
    input  window, win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  en, clr, in0, in1, in2, in3, in4,
    output window, win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window_5x5.sv
// window_5x5: shifts five vertically aligned row taps into a 5x5 register window
// and flags the cycles on which the window is a complete neighbourhood of the frame.
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   bus (slave)  en/clr/in0..in4 in; window/win_valid/win_row/win_col/frame_done out
// Row r=0 of the window is the oldest row (in4), r=4 the newest (in0); c=4 is the newest column.
// Build option: define WINDOW_STRIDE2_EN to report only windows whose top-left
// corner sits on an even row and even column.
module window_5x5 #(
  parameter int unsigned LENGTH    = 32,
  parameter int unsigned HEIGHT    = 32,
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  window_5x5_if.slave  bus
);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned COL_W = $clog2(LENGTH);
  localparam int unsigned WIN_W = 25 * BIT_WIDTH;

  logic [WIN_W-1:0]       win_q, win_d;
  logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
  logic [COL_W-1:0]       col_cnt_q, col_cnt_d;
  logic                   win_valid_q, win_valid_d;
  logic [ROW_W-1:0]       win_row_q, win_row_d;
  logic [COL_W-1:0]       win_col_q, win_col_d;
  logic                   frame_done_q, frame_done_d;
  logic [5*BIT_WIDTH-1:0] taps_c;
  logic                   full_c;
  logic                   stride_ok_c;
  logic                   last_col_c;
  logic                   last_row_c;

  // Tap for window row r sits at slice r: in4 (oldest) lowest, in0 (newest) highest.
  assign taps_c = {bus.in0, bus.in1, bus.in2, bus.in3, bus.in4};

  // Accepted pixel completes a window only with 4 real rows above and 4 real columns to the left.
  assign full_c = (row_cnt_q >= ROW_W'(4)) && (col_cnt_q >= COL_W'(4));

`ifdef WINDOW_STRIDE2_EN
  // Offsets from 4 are even exactly when the counters themselves are even.
  assign stride_ok_c = ~row_cnt_q[0] & ~col_cnt_q[0];
`else
  assign stride_ok_c = 1'b1;
`endif

  assign last_col_c = (col_cnt_q == COL_W'(LENGTH - 1));
  assign last_row_c = (row_cnt_q == ROW_W'(HEIGHT - 1));

  // Next-state: shift, raster counters, and the one-cycle status pulses.
  always_comb begin
    win_d        = win_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    win_valid_d  = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;

    if (bus.clr) begin
      win_d     = '0;
      row_cnt_d = '0;
      col_cnt_d = '0;
    end else if (bus.en) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[(r*5+c)*BIT_WIDTH +: BIT_WIDTH] = win_q[(r*5+c+1)*BIT_WIDTH +: BIT_WIDTH];
        end
        win_d[(r*5+4)*BIT_WIDTH +: BIT_WIDTH] = taps_c[r*BIT_WIDTH +: BIT_WIDTH];
      end

      if (full_c && stride_ok_c) begin
        win_valid_d = 1'b1;
        win_row_d   = row_cnt_q;
        win_col_d   = col_cnt_q;
      end

      frame_done_d = last_col_c && last_row_c;

      if (last_col_c) begin
        col_cnt_d = '0;
        row_cnt_d = last_row_c ? '0 : row_cnt_q + ROW_W'(1);
      end else begin
        col_cnt_d = col_cnt_q + COL_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      row_cnt_q    <= '0;
      col_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      row_cnt_q    <= row_cnt_d;
      col_cnt_q    <= col_cnt_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.window     = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_5x5.sv
// tb_window_5x5: directed + randomized bench for window_5x5 (8x8 frame, 8-bit pixels).
// The bench plays the role of the row-buffer chain: it keeps the current frame in an
// array and presents taps in_k = pixel k rows above the live pixel.
module tb_window_5x5;
  localparam int L  = 8;
  localparam int H  = 8;
  localparam int BW = 8;
  localparam int CW = 200;
`ifdef WINDOW_STRIDE2_EN
  localparam int EXP_PULSES = ((H - 4 + 1) / 2) * ((L - 4 + 1) / 2);
`else
  localparam int EXP_PULSES = (H - 4) * (L - 4);
`endif

  logic clk;
  logic rst_n;

  window_5x5_if #(.LENGTH(L), .HEIGHT(H), .BIT_WIDTH(BW)) bus ();

  window_5x5 #(.LENGTH(L), .HEIGHT(H), .BIT_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          passes;
  int          mr, mc;
  logic [7:0]  img [H][L];
  logic        exp_valid, exp_fd;
  logic [2:0]  exp_wr, exp_wc;
  logic [199:0] exp_win;
  logic        win_known;
  int          obs_pulses;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] wpix(input int r, input int c);
    logic [199:0] w;
    w = bus.window;
    return w[(r*5+c)*8 +: 8];
  endfunction

  // One clock: present a pixel (ramp value or random), update the frame model, check outputs.
  task automatic step(input bit e, input bit c, input bit ramp);
    logic [7:0] pix;
    logic [7:0] t [5];
    bit         v;
    pix  = ramp ? 8'(mr * 8 + mc) : 8'($urandom);
    t[0] = pix;
    for (int k = 1; k < 5; k++) t[k] = (mr >= k) ? img[mr-k][mc] : 8'($urandom);
    bus.en  = e;
    bus.clr = c;
    bus.in0 = t[0];
    bus.in1 = t[1];
    bus.in2 = t[2];
    bus.in3 = t[3];
    bus.in4 = t[4];
    @(posedge clk);
    #1;
    if (c) begin
      exp_valid  = 1'b0;
      exp_fd     = 1'b0;
      exp_win    = '0;
      win_known  = 1'b1;
      mr         = 0;
      mc         = 0;
      obs_pulses = 0;
    end else if (e) begin
      img[mr][mc] = pix;
      v = (mr >= 4) && (mc >= 4);
`ifdef WINDOW_STRIDE2_EN
      v = v && ((mr - 4) % 2 == 0) && ((mc - 4) % 2 == 0);
`endif
      exp_valid = v;
      exp_fd    = (mr == H - 1) && (mc == L - 1);
      if (v) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            exp_win[(i*5+j)*8 +: 8] = img[mr-4+i][mc-4+j];
        win_known = 1'b1;
        exp_wr    = 3'(mr);
        exp_wc    = 3'(mc);
      end else begin
        win_known = 1'b0;
      end
      mc++;
      if (mc == L) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end else begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
    end
    chk("win_valid", CW'(bus.win_valid), CW'(exp_valid));
    chk("frame_done", CW'(bus.frame_done), CW'(exp_fd));
    chk("win_row", CW'(bus.win_row), CW'(exp_wr));
    chk("win_col", CW'(bus.win_col), CW'(exp_wc));
    if (win_known) chk("window", CW'(bus.window), CW'(exp_win));
    if (bus.win_valid === 1'b1) obs_pulses++;
    if (exp_fd) begin
      chk("pulses_per_frame", CW'(obs_pulses), CW'(EXP_PULSES));
      obs_pulses = 0;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    bus.en  = 1'b1;
    bus.clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_window", CW'(bus.window), CW'(0));
    chk("rst_async_valid", CW'(bus.win_valid), CW'(0));
    @(posedge clk);
    #1;
    chk("rst_valid", CW'(bus.win_valid), CW'(0));
    chk("rst_row", CW'(bus.win_row), CW'(0));
    chk("rst_col", CW'(bus.win_col), CW'(0));
    chk("rst_fd", CW'(bus.frame_done), CW'(0));
    chk("rst_window", CW'(bus.window), CW'(0));
    @(negedge clk);
    rst_n      = 1'b1;
    mr         = 0;
    mc         = 0;
    exp_valid  = 1'b0;
    exp_fd     = 1'b0;
    exp_wr     = '0;
    exp_wc     = '0;
    exp_win    = '0;
    win_known  = 1'b1;
    obs_pulses = 0;
  endtask

  initial begin
    int acc;
    checks  = 0;
    passes  = 0;
    rst_n   = 1'b1;
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.in3 = '0;
    bus.in4 = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < L; c++) img[r][c] = '0;
    do_reset();

    // Raster frame of ramp pixels: first window after the 37th accept.
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 1'b1);
    chk("first_valid", CW'(bus.win_valid), CW'(1));
    chk("first_row", CW'(bus.win_row), CW'(4));
    chk("first_col", CW'(bus.win_col), CW'(4));
    chk("first_w00", CW'(wpix(0, 0)), CW'(0));
    chk("first_w22", CW'(wpix(2, 2)), CW'(18));
    chk("first_w44", CW'(wpix(4, 4)), CW'(36));
    for (int i = 37; i < 45; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 45; i < 64; i++) step(1'b1, 1'b0, 1'b1);

    // Ramp frame again, checking the row-wrap window (5,4) directly.
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 1'b1);
`ifndef WINDOW_STRIDE2_EN
    chk("wrap_w44", CW'(wpix(4, 4)), CW'(44));
`endif
    for (int i = 45; i < 64; i++) step(1'b1, 1'b0, 1'b1);

    // Random pixels with en randomly gapped.
    acc = 0;
    while (acc < 64) begin
      bit e;
      e = 1'($urandom_range(0, 1));
      step(e, 1'b0, 1'b0);
      if (e) acc++;
    end
    step(1'b0, 1'b0, 1'b0);

    // Mid-frame reset at pixel (3,2), then a full random frame.
    for (int i = 0; i < 26; i++) step(1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0);

    // clr presented with en at (6,5): pixel dropped, frame restarts.
    for (int i = 0; i < 53; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_window", CW'(bus.window), CW'(0));
    for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 36; i < 64; i++) step(1'b1, 1'b0, 1'b0);

    // Random frame with gaps after the clr-restarted frame.
    acc = 0;
    while (acc < 64) begin
      bit e;
      e = 1'($urandom_range(0, 1));
      step(e, 1'b0, 1'b0);
      if (e) acc++;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
